// File: rtl/rv_decode_issue_pkg.sv
// Shared types and encodings for the RV32I decode/issue stage.
// decoded_t holds everything written into the issue queue at push time.
package rv_decode_issue_pkg;

    typedef enum logic [1:0] {
        UNIT_ALU    = 2'd0,
        UNIT_LSU    = 2'd1,
        UNIT_BRU    = 2'd2,
        UNIT_SYSTEM = 2'd3
    } unit_type_e;

    typedef enum logic [2:0] {
        INST_R = 3'd0,
        INST_I = 3'd1,
        INST_S = 3'd2,
        INST_B = 3'd3,
        INST_U = 3'd4,
        INST_J = 3'd5
    } inst_type_e;

    localparam logic [6:0] OPCODE_LUI      = 7'h37;
    localparam logic [6:0] OPCODE_AUIPC    = 7'h17;
    localparam logic [6:0] OPCODE_OP_IMM   = 7'h13;
    localparam logic [6:0] OPCODE_OP       = 7'h33;
    localparam logic [6:0] OPCODE_LOAD     = 7'h03;
    localparam logic [6:0] OPCODE_STORE    = 7'h23;
    localparam logic [6:0] OPCODE_BRANCH   = 7'h63;
    localparam logic [6:0] OPCODE_JAL      = 7'h6F;
    localparam logic [6:0] OPCODE_JALR     = 7'h67;
    localparam logic [6:0] OPCODE_MISC_MEM = 7'h0F;
    localparam logic [6:0] OPCODE_SYSTEM   = 7'h73;

    // ALU/LSU/BRU ops are {modifier, funct3}; only the fixed codes are named.
    localparam logic [3:0] ALU_ADD     = 4'h0;
    localparam logic [3:0] ALU_SUB     = 4'h8;
    localparam logic [3:0] LSU_STORE   = 4'h8;
    localparam logic [3:0] BRU_JAL     = 4'h8;
    localparam logic [3:0] BRU_JALR    = 4'h9;
    localparam logic [3:0] SYS_FENCE   = 4'h0;
    localparam logic [3:0] SYS_ECALL   = 4'h1;
    localparam logic [3:0] SYS_EBREAK  = 4'h2;
    localparam logic [3:0] SYS_CSR     = 4'h8;
    localparam logic [3:0] SYS_ILLEGAL = 4'hF;

    typedef struct packed {
        unit_type_e  unit_type;
        logic [3:0]  op;
        inst_type_e  inst_type;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        use_pc;
        logic        use_imm;
        logic        illegal;
    } decoded_t;

endpackage

// File: rtl/rv_decode_issue_if.sv
// Fetch-side and issue-side handshake bundle of the decode/issue stage.
// slave is the stage itself, master is whoever drives fetch and consumes issue.
interface rv_decode_issue_if
    import rv_decode_issue_pkg::*;
#(
    parameter int XLEN = 32
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      instruction_i;
    logic [XLEN-1:0]  pc_i;
    logic             out_valid_o;
    logic             out_ready_i;
    unit_type_e       unit_type_o;
    logic [3:0]       op_o;
    inst_type_e       inst_type_o;
    logic [XLEN-1:0]  immediate_o;
    logic [4:0]       rs1_o;
    logic [4:0]       rs2_o;
    logic [4:0]       rd_o;
    logic             use_pc_o;
    logic             use_imm_o;
    logic [XLEN-1:0]  pc_o;
    logic             illegal_o;

    modport slave (
        input  in_valid_i, instruction_i, pc_i, out_ready_i,
        output in_ready_o, out_valid_o, unit_type_o, op_o, inst_type_o, immediate_o,
               rs1_o, rs2_o, rd_o, use_pc_o, use_imm_o, pc_o, illegal_o
    );

    modport master (
        output in_valid_i, instruction_i, pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, unit_type_o, op_o, inst_type_o, immediate_o,
               rs1_o, rs2_o, rd_o, use_pc_o, use_imm_o, pc_o, illegal_o
    );
endinterface

// File: rtl/rv_decode_issue_comb.sv
// Purely combinational RV32I decoder: raw instruction to decoded_t.
// Any illegal encoding collapses to SYSTEM/SYS_ILLEGAL with all indices zero.
module rv_decode_comb
    import rv_decode_issue_pkg::*;
(
    input  logic [31:0] instruction_i,
    output decoded_t    decoded_o
);
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        illegal;
    decoded_t    d;

    assign opcode = instruction_i[6:0];
    assign funct3 = instruction_i[14:12];
    assign funct7 = instruction_i[31:25];
    assign imm_i  = {{20{instruction_i[31]}}, instruction_i[31:20]};
    assign imm_s  = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
    assign imm_b  = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                     instruction_i[30:25], instruction_i[11:8], 1'b0};
    assign imm_u  = {instruction_i[31:12], 12'b0};
    assign imm_j  = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                     instruction_i[20], instruction_i[30:21], 1'b0};

    always_comb begin
        d       = '0;
        illegal = 1'b0;
        case (opcode)
            OPCODE_LUI, OPCODE_AUIPC: begin
                d.unit_type = UNIT_ALU;
                d.inst_type = INST_U;
                d.op        = ALU_ADD;
                d.imm       = imm_u;
                d.rd        = instruction_i[11:7];
                d.use_imm   = 1'b1;
                d.use_pc    = (opcode == OPCODE_AUIPC);
            end
            OPCODE_OP_IMM: begin
                d.unit_type = UNIT_ALU;
                d.inst_type = INST_I;
                d.op        = {funct7[5] & (funct3 == 3'd5), funct3};
                d.imm       = imm_i;
                d.rd        = instruction_i[11:7];
                d.rs1       = instruction_i[19:15];
                d.use_imm   = 1'b1;
                if (funct3 == 3'd1 && funct7 != 7'h00) illegal = 1'b1;
                if (funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20) illegal = 1'b1;
            end
            OPCODE_OP: begin
                d.unit_type = UNIT_ALU;
                d.inst_type = INST_R;
                d.op        = {funct7[5], funct3};
                d.rd        = instruction_i[11:7];
                d.rs1       = instruction_i[19:15];
                d.rs2       = instruction_i[24:20];
                if (!(funct7 == 7'h00 ||
                      (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)))) illegal = 1'b1;
            end
            OPCODE_LOAD: begin
                d.unit_type = UNIT_LSU;
                d.inst_type = INST_I;
                d.op        = {1'b0, funct3};
                d.imm       = imm_i;
                d.rd        = instruction_i[11:7];
                d.rs1       = instruction_i[19:15];
                d.use_imm   = 1'b1;
                if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) illegal = 1'b1;
            end
            OPCODE_STORE: begin
                d.unit_type = UNIT_LSU;
                d.inst_type = INST_S;
                d.op        = LSU_STORE | {1'b0, funct3};
                d.imm       = imm_s;
                d.rs1       = instruction_i[19:15];
                d.rs2       = instruction_i[24:20];
                d.use_imm   = 1'b1;
                if (funct3 > 3'd2) illegal = 1'b1;
            end
            OPCODE_BRANCH: begin
                d.unit_type = UNIT_BRU;
                d.inst_type = INST_B;
                d.op        = {1'b0, funct3};
                d.imm       = imm_b;
                d.rs1       = instruction_i[19:15];
                d.rs2       = instruction_i[24:20];
                if (funct3 == 3'd2 || funct3 == 3'd3) illegal = 1'b1;
            end
            OPCODE_JAL: begin
                d.unit_type = UNIT_BRU;
                d.inst_type = INST_J;
                d.op        = BRU_JAL;
                d.imm       = imm_j;
                d.rd        = instruction_i[11:7];
                d.use_pc    = 1'b1;
                d.use_imm   = 1'b1;
            end
            OPCODE_JALR: begin
                d.unit_type = UNIT_BRU;
                d.inst_type = INST_I;
                d.op        = BRU_JALR;
                d.imm       = imm_i;
                d.rd        = instruction_i[11:7];
                d.rs1       = instruction_i[19:15];
                d.use_imm   = 1'b1;
                if (funct3 != 3'd0) illegal = 1'b1;
            end
            OPCODE_MISC_MEM: begin
                d.unit_type = UNIT_SYSTEM;
                d.inst_type = INST_I;
                d.op        = SYS_FENCE;
            end
            OPCODE_SYSTEM: begin
                d.unit_type = UNIT_SYSTEM;
                d.inst_type = INST_I;
                if (funct3 == 3'd0) begin
                    if (instruction_i[31:20] == 12'd0)      d.op = SYS_ECALL;
                    else if (instruction_i[31:20] == 12'd1) d.op = SYS_EBREAK;
                    else                                    illegal = 1'b1;
                end else if (funct3 == 3'd4) begin
                    illegal = 1'b1;
                end else begin
                    // CSR accesses keep rd/rs1 fields and the CSR address as imm.
                    d.op  = SYS_CSR | {1'b0, funct3};
                    d.imm = imm_i;
                    d.rd  = instruction_i[11:7];
                    d.rs1 = instruction_i[19:15];
                end
            end
            default: illegal = 1'b1;
        endcase

        if (instruction_i[1:0] != 2'b11) illegal = 1'b1;

        if (illegal) begin
            d           = '0;
            d.unit_type = UNIT_SYSTEM;
            d.inst_type = INST_I;
            d.op        = SYS_ILLEGAL;
            d.illegal   = 1'b1;
        end
    end

    assign decoded_o = d;
endmodule

// File: rtl/rv_decode_issue.sv
// Decode/issue stage: decodes at push and buffers results in a DEPTH-entry FIFO.
// Handshake: a transfer happens on a rising edge where valid && ready; flush_i kills both sides.
module rv_decode_issue
    import rv_decode_issue_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
)(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    rv_decode_issue_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    decoded_t        dec;
    decoded_t        entries_q [DEPTH];
    decoded_t        entries_d [DEPTH];
    logic [XLEN-1:0] pcs_q [DEPTH];
    logic [XLEN-1:0] pcs_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic            in_ready, out_valid, push, pop;
    decoded_t        head;

    rv_decode_comb u_decode (
        .instruction_i (bus.instruction_i),
        .decoded_o     (dec)
    );

    // Ready and valid come from registered count only, never from out_ready_i.
    assign in_ready  = (count_q != (PW+1)'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = bus.in_valid_i && in_ready && !flush_i;
    assign pop       = out_valid && bus.out_ready_i && !flush_i;

    always_comb begin
        entries_d = entries_q;
        pcs_d     = pcs_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                entries_d[wr_ptr_q] = dec;
                pcs_d[wr_ptr_q]     = bus.pc_i;
                wr_ptr_d            = wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
                pcs_q[i]     <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            entries_q <= entries_d;
            pcs_q     <= pcs_d;
        end
    end

    always_comb begin
        head            = out_valid ? entries_q[rd_ptr_q] : '0;
        bus.in_ready_o  = in_ready;
        bus.out_valid_o = out_valid;
        bus.unit_type_o = head.unit_type;
        bus.op_o        = head.op;
        bus.inst_type_o = head.inst_type;
        bus.immediate_o = XLEN'($signed(head.imm));
        bus.rs1_o       = head.rs1;
        bus.rs2_o       = head.rs2;
        bus.rd_o        = head.rd;
        bus.use_pc_o    = head.use_pc;
        bus.use_imm_o   = head.use_imm;
        bus.illegal_o   = head.illegal;
        bus.pc_o        = out_valid ? pcs_q[rd_ptr_q] : '0;
    end
endmodule

// File: tb/tb_rv_decode_issue.sv
// Bench for rv_decode_issue: directed scenarios plus a randomized run scored
// against a queue-based reference model of the decode rules.
module tb_rv_decode_issue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [1:0]  unit;
        logic [3:0]  op;
        logic [2:0]  itype;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        use_pc;
        logic        use_imm;
        logic        illegal;
        logic [31:0] pc;
    } exp_t;
    localparam int W = $bits(exp_t);

    logic clk_i = 1'b0;
    logic rst_ni;
    logic flush_i;
    int   errors = 0;
    int   checks = 0;
    logic [W-1:0] exp_q[$];

    rv_decode_issue_if #(.XLEN(XLEN)) bus ();

    rv_decode_issue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        bus.in_valid_i    = v;
        bus.instruction_i = ins;
        bus.pc_i          = pc;
        bus.out_ready_i   = rdy;
        flush_i           = fl;
    endtask

    // ---------------- reference model ----------------
    function automatic exp_t mk(input logic [1:0] unit, input logic [3:0] op, input logic [2:0] it,
                                input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic upc, input logic uimm,
                                input logic ill, input logic [31:0] pc);
        exp_t e;
        e = '{unit, op, it, imm, rs1, rs2, rd, upc, uimm, ill, pc};
        return e;
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t        r;
        logic        ill;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] ii, is, ib, iu, ij;
        opc = ins[6:0];   f3  = ins[14:12]; f7  = ins[31:25];
        rd  = ins[11:7];  rs1 = ins[19:15]; rs2 = ins[24:20];
        ii  = 32'($signed(ins[31:20]));
        is  = 32'($signed({ins[31:25], ins[11:7]}));
        ib  = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2;
        iu  = ins & 32'hFFFF_F000;
        ij  = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2;
        ill = (ins[1:0] != 2'b11);
        r   = '0;
        case (opc)
            7'h37: r = mk(2'd0, 4'd0, 3'd4, iu, 5'd0, 5'd0, rd, 1'b0, 1'b1, 1'b0, pc);
            7'h17: r = mk(2'd0, 4'd0, 3'd4, iu, 5'd0, 5'd0, rd, 1'b1, 1'b1, 1'b0, pc);
            7'h13: begin
                r = mk(2'd0, {(f3 == 3'd5) && (f7 == 7'h20), f3}, 3'd1, ii, rs1, 5'd0, rd,
                       1'b0, 1'b1, 1'b0, pc);
                if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
                if (f3 == 3'd5 && !(f7 == 7'h00 || f7 == 7'h20)) ill = 1'b1;
            end
            7'h33: begin
                r = mk(2'd0, {f7 == 7'h20, f3}, 3'd0, 32'd0, rs1, rs2, rd, 1'b0, 1'b0, 1'b0, pc);
                if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) ill = 1'b1;
            end
            7'h03: begin
                r = mk(2'd1, {1'b0, f3}, 3'd1, ii, rs1, 5'd0, rd, 1'b0, 1'b1, 1'b0, pc);
                if (f3 == 3'd3 || f3 >= 3'd6) ill = 1'b1;
            end
            7'h23: begin
                r = mk(2'd1, 4'd8 + {1'b0, f3}, 3'd2, is, rs1, rs2, 5'd0, 1'b0, 1'b1, 1'b0, pc);
                if (f3 > 3'd2) ill = 1'b1;
            end
            7'h63: begin
                r = mk(2'd2, {1'b0, f3}, 3'd3, ib, rs1, rs2, 5'd0, 1'b0, 1'b0, 1'b0, pc);
                if (f3 == 3'd2 || f3 == 3'd3) ill = 1'b1;
            end
            7'h6F: r = mk(2'd2, 4'd8, 3'd5, ij, 5'd0, 5'd0, rd, 1'b1, 1'b1, 1'b0, pc);
            7'h67: begin
                r = mk(2'd2, 4'd9, 3'd1, ii, rs1, 5'd0, rd, 1'b0, 1'b1, 1'b0, pc);
                if (f3 != 3'd0) ill = 1'b1;
            end
            7'h0F: r = mk(2'd3, 4'd0, 3'd1, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, pc);
            7'h73: begin
                if (f3 == 3'd0) begin
                    if (ins[31:20] == 12'd0)      r = mk(2'd3, 4'd1, 3'd1, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, pc);
                    else if (ins[31:20] == 12'd1) r = mk(2'd3, 4'd2, 3'd1, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, pc);
                    else                          ill = 1'b1;
                end else if (f3 == 3'd4) begin
                    ill = 1'b1;
                end else begin
                    r = mk(2'd3, 4'd8 + {1'b0, f3}, 3'd1, ii, rs1, 5'd0, rd, 1'b0, 1'b0, 1'b0, pc);
                end
            end
            default: ill = 1'b1;
        endcase
        if (ill) r = mk(2'd3, 4'hF, 3'd1, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, pc);
        return r;
    endfunction

    function automatic exp_t obs();
        exp_t o;
        o.unit    = bus.unit_type_o;
        o.op      = bus.op_o;
        o.itype   = bus.inst_type_o;
        o.imm     = bus.immediate_o;
        o.rs1     = bus.rs1_o;
        o.rs2     = bus.rs2_o;
        o.rd      = bus.rd_o;
        o.use_pc  = bus.use_pc_o;
        o.use_imm = bus.use_imm_o;
        o.illegal = bus.illegal_o;
        o.pc      = bus.pc_o;
        return o;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0]  opcs [11];
        logic [31:0] ins;
        int          k;
        opcs = '{7'h37, 7'h17, 7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h0F, 7'h73};
        ins  = $urandom;
        k    = $urandom_range(0, 12);
        if (k < 11) ins[6:0] = opcs[k];
        if ($urandom_range(0, 2) == 0) ins[31:25] = 7'h00;
        else if ($urandom_range(0, 2) == 0) ins[31:25] = 7'h20;
        if (ins[6:0] == 7'h73 && ins[14:12] == 3'd0 && $urandom_range(0, 1) == 1)
            ins[31:20] = 12'($urandom_range(0, 1));
        return ins;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst_ni = 1'b0;
        #12;
        checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid_o); end
        checks++; if (obs() !== exp_t'('0)) begin errors++; $display("FAIL reset_head_zero got=%h exp=0", obs()); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        checks++; if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1)
            begin errors++; $display("FAIL post_reset got valid=%b ready=%b exp valid=0 ready=1", bus.out_valid_o, bus.in_ready_o); end
    endtask

    task automatic test_addi();
        exp_t e;
        e = mk(2'd0, 4'd0, 3'd1, 32'd5, 5'd0, 5'd0, 5'd1, 1'b0, 1'b1, 1'b0, 32'h100);
        drive(1'b1, 32'h0050_0093, 32'h100, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL addi_latency got=%b exp=1", bus.out_valid_o); end
        checks++; if (obs() !== e) begin errors++; $display("FAIL addi_fields got=%h exp=%h", obs(), e); end
        bus.out_ready_i = 1'b1;
        tick();
        checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL addi_pop got=%b exp=0", bus.out_valid_o); end
    endtask

    task automatic test_sub_sw();
        exp_t e_sub, e_sw;
        e_sub = mk(2'd0, 4'b1000, 3'd0, 32'd0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 32'h200);
        e_sw  = mk(2'd1, 4'b1010, 3'd2, 32'd8, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 32'h204);
        drive(1'b1, 32'h4020_81B3, 32'h200, 1'b1, 1'b0);
        tick();
        checks++; if (obs() !== e_sub) begin errors++; $display("FAIL sub_fields got=%h exp=%h", obs(), e_sub); end
        drive(1'b1, 32'h0020_A423, 32'h204, 1'b1, 1'b0);
        tick();
        checks++; if (obs() !== e_sw) begin errors++; $display("FAIL sw_fields got=%h exp=%h", obs(), e_sw); end
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        tick();
        checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL sub_sw_drain got=%b exp=0", bus.out_valid_o); end
    endtask

    task automatic test_branch_illegal_lui();
        logic [31:0] ins [3];
        exp_t        e   [3];
        ins  = '{32'hFE20_8EE3, 32'h0000_0000, 32'h1234_52B7};
        e[0] = mk(2'd2, 4'd0, 3'd3, 32'hFFFF_FFFC, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 32'h300);
        e[1] = mk(2'd3, 4'hF, 3'd1, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h304);
        e[2] = mk(2'd0, 4'd0, 3'd4, 32'h1234_5000, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 32'h308);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ins[i], 32'h300 + 32'(4 * i), 1'b1, 1'b0);
            tick();
            checks++; if (obs() !== e[i]) begin errors++; $display("FAIL directed_%0d got=%h exp=%h", i, obs(), e[i]); end
        end
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_backpressure();
        drive(1'b1, 32'h0010_0093, 32'h400, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0020_0093, 32'h404, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0030_0093, 32'h408, 1'b0, 1'b0);
        checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", bus.in_ready_o); end
        tick();
        checks++; if (bus.in_ready_o !== 1'b0 || bus.pc_o !== 32'h400)
            begin errors++; $display("FAIL full_hold got ready=%b pc=%h exp ready=0 pc=400", bus.in_ready_o, bus.pc_o); end
        bus.out_ready_i = 1'b1;
        tick();
        checks++; if (bus.pc_o !== 32'h404 || bus.in_ready_o !== 1'b1)
            begin errors++; $display("FAIL drain_1 got pc=%h ready=%b exp pc=404 ready=1", bus.pc_o, bus.in_ready_o); end
        tick();
        bus.in_valid_i = 1'b0;
        checks++; if (bus.pc_o !== 32'h408 || bus.rd_o !== 5'd1)
            begin errors++; $display("FAIL drain_2 got pc=%h rd=%0d exp pc=408 rd=1", bus.pc_o, bus.rd_o); end
        tick();
        checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", bus.out_valid_o); end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h0010_0093, 32'h500, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0020_0093, 32'h504, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0030_0093, 32'h508, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        checks++; if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1)
            begin errors++; $display("FAIL flush_full got valid=%b ready=%b exp valid=0 ready=1", bus.out_valid_o, bus.in_ready_o); end
        drive(1'b1, 32'h0040_0093, 32'h510, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0050_0093, 32'h514, 1'b0, 1'b1);
        tick();
        checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_drops_input got=%b exp=0", bus.out_valid_o); end
        drive(1'b1, 32'h0060_0093, 32'h600, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0070_0093, 32'h604, 1'b0, 1'b0);
        checks++; if (bus.pc_o !== 32'h600) begin errors++; $display("FAIL flush_ptr_reset got pc=%h exp=600", bus.pc_o); end
        tick();
        bus.in_valid_i = 1'b0;
        checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL flush_count_zero got ready=%b exp=0", bus.in_ready_o); end
        bus.out_ready_i = 1'b1;
        tick();
        tick();
        checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL flush_drain got=%b exp=0", bus.out_valid_o); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h0080_0093, 32'h700, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL midrst_pre got=%b exp=1", bus.out_valid_o); end
        rst_ni = 1'b0;
        #1;
        checks++; if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1)
            begin errors++; $display("FAIL midrst_async got valid=%b ready=%b exp valid=0 ready=1", bus.out_valid_o, bus.in_ready_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_after got=%b exp=0", bus.out_valid_o); end
    endtask

    task automatic test_random();
        logic        v, rdy, fl, exp_v, exp_r;
        logic [31:0] ins, pc;
        exp_t        head_exp;
        exp_q.delete();
        for (int cyc = 0; cyc < 800; cyc++) begin
            exp_v = (exp_q.size() != 0);
            exp_r = (exp_q.size() < DEPTH);
            checks++; if (bus.out_valid_o !== exp_v) begin errors++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid_o, exp_v); end
            checks++; if (bus.in_ready_o !== exp_r) begin errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready_o, exp_r); end
            if (exp_v) begin
                head_exp = exp_q[0];
                checks++; if (obs() !== head_exp) begin errors++; $display("FAIL rand_head cyc=%0d got=%h exp=%h", cyc, obs(), head_exp); end
            end
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 39) == 0);
            ins = rand_inst();
            pc  = $urandom & 32'hFFFF_FFFC;
            drive(v, ins, pc, rdy, fl);
            if (fl) exp_q.delete();
            else begin
                if (exp_v && rdy) void'(exp_q.pop_front());
                if (v && exp_r) exp_q.push_back(model(ins, pc));
            end
            tick();
        end
        drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
        tick();
        tick();
        checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL rand_final_drain got=%b exp=0", bus.out_valid_o); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sub_sw();
        test_branch_illegal_lui();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
